// File: rtl/ieee_pkg.sv
// ieee_pkg: shared single-precision constants and helpers for the custom FP
// datapath (round/pack, converter, add/sub).
//   EXP_LEN / FRAC_LEN / BIAS / EXP_INF : IEEE-754 single-precision geometry
//   ieee_t                              : {sign, exp, frac} view of a packed word
//   pack_ieee / unpack_ieee             : assemble / split a packed word
package ieee_pkg;

  localparam int EXP_LEN  = 8;
  localparam int FRAC_LEN = 23;
  localparam int BIAS     = (1 << (EXP_LEN - 1)) - 1;
  localparam int WORD_LEN = 1 + EXP_LEN + FRAC_LEN;

  localparam logic [EXP_LEN-1:0] EXP_INF = '1;

  typedef struct packed {
    logic                sign;
    logic [EXP_LEN-1:0]  exp;
    logic [FRAC_LEN-1:0] frac;
  } ieee_t;

  function automatic logic [WORD_LEN-1:0] pack_ieee(input logic                sign,
                                                    input logic [EXP_LEN-1:0]  exp,
                                                    input logic [FRAC_LEN-1:0] frac);
    return {sign, exp, frac};
  endfunction

  function automatic ieee_t unpack_ieee(input logic [WORD_LEN-1:0] word);
    return ieee_t'(word);
  endfunction

endpackage

// File: rtl/customized_round_pack_rne_rounder.sv
// rne_rounder: combinational round-to-nearest-even on a kept mantissa.
//   kept_i    : fraction bits that survive truncation
//   guard_i   : first discarded bit
//   sticky_i  : OR of all remaining discarded bits
//   frac_o    : rounded fraction (all zeros when carry_o is set)
//   carry_o   : rounding overflowed the implicit leading 1 (exponent must bump)
//   inexact_o : some discarded bit was 1
module rne_rounder #(
  parameter int W = 23
) (
  input  logic [W-1:0] kept_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] frac_o,
  output logic         carry_o,
  output logic         inexact_o
);

  logic         round_up;
  logic [W:0]   m;

  // Round up above half, or exactly at half when the kept LSB is odd (ties to even).
  assign round_up  = guard_i & (sticky_i | kept_i[0]);
  assign m         = {1'b0, kept_i} + {{W{1'b0}}, round_up};
  // On carry the low W bits of m are already zero (all-ones + 1).
  assign frac_o    = m[W-1:0];
  assign carry_o   = m[W];
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/customized_round_pack.sv
// customized_round_pack: two-stage round/pack of the wide multiplier product
// into an IEEE-754 single-precision word (RNE, exponent carry, overflow to
// infinity, flush-to-zero, inf/NaN pass-through).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_val = {sign, biased exp, fraction}
//   out_valid/out_ready : output handshake
//   ieee_val            : packed result {sign, exp, frac}
//   overflow            : result saturated to +/-inf
//   underflow           : nonzero input flushed to +/-0
//   inexact             : a discarded fraction bit was 1
//
// Handshake: a beat transfers on a rising edge where valid && ready. Valid
// never depends on ready. While out_valid && !out_ready the output word and
// flags are held. S2 loads when it is empty or being drained; S1 loads when it
// is empty or S2 loads, so in_ready is simply "S1 can load this cycle".
module customized_round_pack
  import ieee_pkg::*;
#(
  parameter int in_montissa_len  = 47,
  parameter int out_montissa_len = FRAC_LEN,
  parameter int exp_len          = EXP_LEN
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [exp_len+in_montissa_len:0]      in_val,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [exp_len+out_montissa_len:0]     ieee_val,
  output logic                                  overflow,
  output logic                                  underflow,
  output logic                                  inexact
);

  localparam int DROP = in_montissa_len - out_montissa_len;

  // Input field split
  logic                        in_sign;
  logic [exp_len-1:0]          in_exp;
  logic [in_montissa_len-1:0]  in_frac;

  assign in_sign = in_val[exp_len+in_montissa_len];
  assign in_exp  = in_val[exp_len+in_montissa_len-1 -: exp_len];
  assign in_frac = in_val[in_montissa_len-1:0];

  // S1 (decode) registers
  logic                        s1_v_q;
  logic                        s1_sign_q;
  logic [exp_len-1:0]          s1_exp_q;
  logic [out_montissa_len-1:0] s1_kept_q;
  logic                        s1_guard_q;
  logic                        s1_sticky_q;
  logic                        s1_zero_q;
  logic                        s1_special_q;
  logic                        s1_frac_nz_q;

  // S2 (output) registers and their next values
  logic                              out_valid_q;
  logic [exp_len+out_montissa_len:0] ieee_q, ieee_d;
  logic                              ovf_q, ovf_d;
  logic                              unf_q, unf_d;
  logic                              inx_q, inx_d;

  logic s1_load, s2_load;

  assign s2_load  = !out_valid_q | out_ready;
  assign s1_load  = !s1_v_q | s2_load;
  assign in_ready = s1_load;

  // Rounding of the S1 contents
  logic [out_montissa_len-1:0] rnd_frac;
  logic                        rnd_carry;
  logic                        rnd_inexact;
  logic [exp_len:0]            e_ext;

  rne_rounder #(.W(out_montissa_len)) u_rne (
    .kept_i    (s1_kept_q),
    .guard_i   (s1_guard_q),
    .sticky_i  (s1_sticky_q),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  // One extra bit so exp=all-ones-minus-one plus carry is visible as overflow.
  assign e_ext = {1'b0, s1_exp_q} + {{exp_len{1'b0}}, rnd_carry};

  always_comb begin
    ieee_d = {s1_sign_q, e_ext[exp_len-1:0], rnd_frac};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = rnd_inexact;
    if (s1_special_q) begin
      // inf/NaN from upstream: no rounding; a NaN keeps a nonzero fraction.
      ieee_d = {s1_sign_q, {exp_len{1'b1}},
                s1_kept_q | {s1_frac_nz_q, {(out_montissa_len-1){1'b0}}}};
      inx_d  = 1'b0;
    end else if (s1_zero_q) begin
      ieee_d = {s1_sign_q, {exp_len{1'b0}}, {out_montissa_len{1'b0}}};
      unf_d  = s1_frac_nz_q;
      inx_d  = 1'b0;
    end else if (e_ext >= {1'b0, {exp_len{1'b1}}}) begin
      ieee_d = {s1_sign_q, {exp_len{1'b1}}, {out_montissa_len{1'b0}}};
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_kept_q    <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_frac_nz_q <= 1'b0;
      out_valid_q  <= 1'b0;
      ieee_q       <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      inx_q        <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_sign_q    <= in_sign;
          s1_exp_q     <= in_exp;
          s1_kept_q    <= in_frac[in_montissa_len-1 -: out_montissa_len];
          s1_guard_q   <= in_frac[DROP-1];
          s1_sticky_q  <= |in_frac[DROP-2:0];
          s1_zero_q    <= (in_exp == '0);
          s1_special_q <= (in_exp == {exp_len{1'b1}});
          s1_frac_nz_q <= |in_frac;
        end
      end
      if (s2_load) begin
        out_valid_q <= s1_v_q;
        if (s1_v_q) begin
          ieee_q <= ieee_d;
          ovf_q  <= ovf_d;
          unf_q  <= unf_d;
          inx_q  <= inx_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ieee_val  = ieee_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_customized_round_pack.sv
module tb_customized_round_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] in_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ieee_val;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  customized_round_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ieee_val  (ieee_val),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver: send one beat with out_ready high, wait (bounded) for the result
  task automatic run_beat(input logic [55:0] v, output logic [31:0] r,
                          output logic [2:0] f, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_val    = v;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    r = ieee_val;
    f = {overflow, underflow, inexact};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (ieee_val !== 32'h0) begin errors++; $display("FAIL reset_ieee_val got %h want 00000000", ieee_val); end
    checks++;
    if ({overflow, underflow, inexact} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {overflow, underflow, inexact});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  // rounding, carry, overflow, flush-to-zero, signed and round-down vectors
  task automatic test_round();
    logic [55:0] vin  [9] = '{
      {1'b0, 8'd127, 47'h400000000000},
      {1'b0, 8'd127, {23'h000001, 1'b1, 23'h0}},
      {1'b0, 8'd127, {23'h000000, 1'b1, 23'h0}},
      {1'b0, 8'd127, {23'h7FFFFF, 1'b1, 23'h0}},
      {1'b0, 8'd254, {23'h7FFFFF, 1'b1, 23'h0}},
      {1'b1, 8'd0,   47'h000000001234},
      {1'b1, 8'd130, {23'h123456, 1'b1, 23'h000001}},
      {1'b0, 8'd100, {23'h000005, 1'b0, 23'h000001}},
      {1'b1, 8'd0,   47'h0}
    };
    logic [31:0] vexp [9] = '{
      32'h3FC00000, 32'h3F800002, 32'h3F800000, 32'h40000000, 32'h7F800000,
      32'h80000000, 32'hC1123457, 32'h32000005, 32'h80000000
    };
    // {overflow, underflow, inexact}
    logic [2:0] vflg [9] = '{
      3'b000, 3'b001, 3'b001, 3'b001, 3'b101, 3'b010, 3'b001, 3'b001, 3'b000
    };
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_beat(vin[i], r, f, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL round_latency[%0d] got %0d want 2", i, lat); end
      checks++;
      if (r !== vexp[i]) begin errors++; $display("FAIL round_value[%0d] got %h want %h", i, r, vexp[i]); end
      checks++;
      if (f !== vflg[i]) begin errors++; $display("FAIL round_flags[%0d] got %b want %b", i, f, vflg[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    run_beat({1'b0, 8'd255, 47'h000000000001}, r, f, lat);
    checks++;
    if (r !== 32'h7FC00000) begin errors++; $display("FAIL nan_pass got %h want 7FC00000", r); end
    run_beat({1'b1, 8'd255, 47'h0}, r, f, lat);
    checks++;
    if (r !== 32'hFF800000) begin errors++; $display("FAIL inf_pass got %h want FF800000", r); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] beats [4] = '{
      {1'b0, 8'd127, 47'h400000000000},
      {1'b0, 8'd127, {23'h000001, 1'b1, 23'h0}},
      {1'b0, 8'd127, {23'h7FFFFF, 1'b1, 23'h0}},
      {1'b1, 8'd0,   47'h000000001234}
    };
    logic [31:0] held = '0;
    logic [34:0] e;
    logic        fire_in, fire_out;
    int          sent = 0;
    int          got  = 0;
    exp_q.delete();
    exp_q.push_back({3'b000, 32'h3FC00000});
    exp_q.push_back({3'b001, 32'h3F800002});
    exp_q.push_back({3'b001, 32'h40000000});
    exp_q.push_back({3'b010, 32'h80000000});
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) in_val = beats[sent];
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full[%0d] got %b want 0", cyc, in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", cyc, out_valid); end
      end
      if (cyc == 2) held = ieee_val;
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if (ieee_val !== held) begin errors++; $display("FAIL bp_stable[%0d] got %h want %h", cyc, ieee_val, held); end
      end
      if (cyc == 5) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %b want 1", in_ready); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat got %h want none", ieee_val);
        end else begin
          e = exp_q.pop_front();
          if ({overflow, underflow, inexact, ieee_val} !== e) begin
            errors++;
            $display("FAIL bp_beat[%0d] got %b/%h want %b/%h", got,
                     {overflow, underflow, inexact}, ieee_val, e[34:32], e[31:0]);
          end
        end
        got++;
      end
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    int          stale = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_val    = {1'b0, 8'd127, 47'h400000000000};
    @(negedge clk);
    in_val    = {1'b0, 8'd127, {23'h000001, 1'b1, 23'h0}};
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_out_valid got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
    checks++;
    if (ieee_val !== 32'h0) begin errors++; $display("FAIL rst_async_ieee got %h want 00000000", ieee_val); end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL rst_stale_beats got %0d want 0", stale); end
    run_beat({1'b0, 8'd128, 47'h200000000000}, r, f, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rst_fresh_latency got %0d want 2", lat); end
    checks++;
    if (r !== 32'h40200000) begin errors++; $display("FAIL rst_fresh_value got %h want 40200000", r); end
    checks++;
    if (f !== 3'b000) begin errors++; $display("FAIL rst_fresh_flags got %b want 000", f); end
  endtask

  initial begin
    test_reset();
    test_round();
    test_special();
    test_back_to_back();
    test_reset_midflight();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
